// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULTU/DIVU sequencer.
// It borrows the shared ALU for one add/subtract per cycle.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_f,
    input  logic [XLEN-1:0] alu_y,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;

    state_t          state;
    logic            opr;
    logic [XLEN-1:0] d;
    logic [CNTW-1:0] cnt;

    logic [XLEN-1:0] rsh;
    logic            c;
    logic            nb;
    logic            q;

    assign rsh = {hi[XLEN-2:0], lo[XLEN-1]};

    // ALU operand mux: idle drives a quiet add of zeros
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = F_ADD;
        if (state == RUN) begin
            alu_b = d;
            if (opr) begin
                alu_a = rsh;
                alu_f = F_SUB;
            end else begin
                alu_a = hi;
            end
        end
    end

    // Carry-out of the add and no-borrow of the subtract, rebuilt from MSBs
    always_comb begin
        c  = (alu_a[XLEN-1] & alu_b[XLEN-1])
           | ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~alu_y[XLEN-1]);
        nb = (alu_a[XLEN-1] & ~alu_b[XLEN-1])
           | ((alu_a[XLEN-1] | ~alu_b[XLEN-1]) & ~alu_y[XLEN-1]);
        q  = hi[XLEN-1] | nb;
    end

    // Sequencer FSM with HI/LO datapath and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            opr     <= 1'b0;
            d       <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            alu_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (done) begin
                        busy <= 1'b0;
                    end
                    if (start && !busy) begin
                        opr  <= op;
                        d    <= srcb;
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (op && srcb == '0) begin
                            hi    <= srca;
                            lo    <= '1;
                            state <= DONE;
                        end else begin
                            hi      <= '0;
                            lo      <= srca;
                            alu_req <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (opr) begin
                        hi <= q ? alu_y : rsh;
                        lo <= {lo[XLEN-2:0], q};
                    end else if (lo[0]) begin
                        hi <= {c, alu_y[XLEN-1:1]};
                        lo <= {alu_y[0], lo[XLEN-1:1]};
                    end else begin
                        hi <= {1'b0, hi[XLEN-1:1]};
                        lo <= {hi[0], lo[XLEN-1:1]};
                    end
                    if (cnt == CNTW'(XLEN - 1)) begin
                        alu_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq.
// Reference ALU is modelled here; results go through a queue.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [63:0] sbq[$];

    muldiv_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .alu_req (alu_req),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_f   (alu_f),
        .alu_y   (alu_y),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: subtract for 110, add otherwise
    assign alu_y = (alu_f == 3'b110) ? alu_a - alu_b : alu_a + alu_b;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int poke);
        logic [63:0] e;
        int j;
        int req;
        int extra;
        logic seen;
        if (!o)
            e = 64'(a) * 64'(b);
        else if (b == 32'd0)
            e = {a, 32'hFFFF_FFFF};
        else
            e = {a % b, a / b};
        sbq.push_back(e);
        @(negedge clk);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j     = 0;
        req   = 0;
        seen  = 1'b0;
        while (j < 100) begin
            if (alu_req) req++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (j == poke) begin
                start = 1'b1;
                op    = 1'b1;
                srca  = 32'd99;
                srcb  = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(j), 64'(lat));
        chk({tag, "_alu_req_cycles"}, 64'(req),
            (o && b == 32'd0) ? 64'd0 : 64'd32);
        if (sbq.size() > 0)
            chk({tag, "_hilo"}, {hi, lo}, sbq.pop_front());
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
        chk({tag, "_hold"}, {hi, lo}, e);
        if (poke >= 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({tag, "_extra_done"}, 64'(extra), 64'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hi"}, 64'(hi), 64'd0);
        chk({tag, "_lo"}, 64'(lo), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_alu_req"}, 64'(alu_req), 64'd0);
        chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
        chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
        chk({tag, "_alu_f"}, 64'(alu_f), 64'd2);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        srca  = 32'd0;
        srcb  = 32'd0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_7x9", 1'b0, 32'd7, 32'd9, 33, -1);
        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 33, -1);
        run_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 33, -1);
        run_op("div_msb", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, -1);
        run_op("div_by0", 1'b1, 32'd1234, 32'd0, 1, -1);
        run_op("mul_restart", 1'b0, 32'd3, 32'd5, 33, 10);
        run_op("mul_mix", 1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 33, -1);
        run_op("div_mix", 1'b1, 32'hDEAD_BEEF, 32'h0001_2345, 33, -1);

        @(negedge clk);
        op    = 1'b0;
        srca  = 32'h1234_5678;
        srcb  = 32'h9ABC_DEF1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        chk("midrun_alu_req", 64'(alu_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_6x6", 1'b0, 32'd6, 32'd6, 33, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
